sync_gate_queue: RTL and testbench

- Single-clock, multi-slot successor of the one-entry data gate.
- DEPTH slots each pass ownership between a writer side (src) and a reader side (dst), keeping the gate's Open/Write/Read semantics.
- A programmable hand-over delay, HANDOVER cycles, is added so same-domain paths keep gate-like timing.
- Used where a producer/consumer pair shares a clock but must keep the gate interface, e.g. a bypass build of a CDC path or buffered local mailboxes.

---
 rtl/sync_gate_queue.sv | 137 +++++++++++++
 tb/tb_sync_gate_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_gate_queue.sv
// sync_gate_queue: single-clock multi-slot data gate.
// Each slot passes ownership between the writer (src) and reader (dst) sides,
// with a programmable hand-over delay so timing stays gate-like.
//
// Per-slot state table:
//   state   | meaning
//   SRC_OWN | slot free, writable by src when at wrPtr
//   TO_DST  | written, counting down HANDOVER before dst may see it
//   DST_OWN | readable by dst when at rdPtr
//   TO_SRC  | released, counting down HANDOVER before src may reuse it
module sync_gate_queue #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int HANDOVER = 2
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       srcWrite_i,
    input  logic [WIDTH-1:0]           srcData_i,
    output logic                       srcOpen_o,
    input  logic                       dstRead_i,
    output logic [WIDTH-1:0]           dstData_o,
    output logic                       dstOpen_o,
    output logic [$clog2(DEPTH+1)-1:0] dstCount_o,
    input  logic                       clrErr_i,
    output logic                       errWrite_o,
    output logic                       errRead_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (HANDOVER > 0) ? $clog2(HANDOVER + 1) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_OWN = 2'd0,
        TO_DST  = 2'd1,
        DST_OWN = 2'd2,
        TO_SRC  = 2'd3
    } slotState_t;

    slotState_t       slotSt     [DEPTH];
    slotState_t       slotStNext [DEPTH];
    logic [CW-1:0]    cnt        [DEPTH];
    logic [CW-1:0]    cntNext    [DEPTH];
    logic [WIDTH-1:0] data       [DEPTH];
    logic [WIDTH-1:0] dataNext   [DEPTH];
    logic [PW-1:0]    wrPtr, wrPtrNext;
    logic [PW-1:0]    rdPtr, rdPtrNext;
    logic             errWrite, errWriteNext;
    logic             errRead, errReadNext;
    logic             wrHon, rdHon;
    logic [NW-1:0]    dstCount;

    assign srcOpen_o  = (slotSt[wrPtr] == SRC_OWN);
    assign dstOpen_o  = (slotSt[rdPtr] == DST_OWN);
    assign dstData_o  = data[rdPtr];
    assign dstCount_o = dstCount;
    assign errWrite_o = errWrite;
    assign errRead_o  = errRead;

    // A request is only honoured when the slot at its pointer is open to that side.
    assign wrHon = srcWrite_i & srcOpen_o;
    assign rdHon = dstRead_i & dstOpen_o;

    // Next-state for every slot, both pointers and the sticky error flags.
    always_comb begin
        wrPtrNext    = wrPtr;
        rdPtrNext    = rdPtr;
        errWriteNext = (errWrite & ~clrErr_i) | (srcWrite_i & ~srcOpen_o);
        errReadNext  = (errRead & ~clrErr_i) | (dstRead_i & ~dstOpen_o);
        for (int i = 0; i < DEPTH; i++) begin
            slotStNext[i] = slotSt[i];
            cntNext[i]    = cnt[i];
            dataNext[i]   = data[i];
            case (slotSt[i])
                SRC_OWN: begin
                    if (wrHon && (wrPtr == PW'(i))) begin
                        slotStNext[i] = TO_DST;
                        cntNext[i]    = CW'(HANDOVER);
                        dataNext[i]   = srcData_i;
                    end
                end
                TO_DST: begin
                    if (cnt[i] == '0) slotStNext[i] = DST_OWN;
                    else              cntNext[i]    = cnt[i] - CW'(1);
                end
                DST_OWN: begin
                    if (rdHon && (rdPtr == PW'(i))) begin
                        slotStNext[i] = TO_SRC;
                        cntNext[i]    = CW'(HANDOVER);
                    end
                end
                TO_SRC: begin
                    if (cnt[i] == '0) slotStNext[i] = SRC_OWN;
                    else              cntNext[i]    = cnt[i] - CW'(1);
                end
                default: slotStNext[i] = SRC_OWN;
            endcase
        end
        if (wrHon) wrPtrNext = (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
        if (rdHon) rdPtrNext = (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
    end

    // Readable-slot count follows the registered slot states directly.
    always_comb begin
        dstCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotSt[i] == DST_OWN) dstCount = dstCount + NW'(1);
        end
    end

    // State register; synchronous reset discards all in-flight hand-overs and data.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            errWrite <= 1'b0;
            errRead  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slotSt[i] <= SRC_OWN;
                cnt[i]    <= '0;
                data[i]   <= '0;
            end
        end else begin
            wrPtr    <= wrPtrNext;
            rdPtr    <= rdPtrNext;
            errWrite <= errWriteNext;
            errRead  <= errReadNext;
            for (int i = 0; i < DEPTH; i++) begin
                slotSt[i] <= slotStNext[i];
                cnt[i]    <= cntNext[i];
                data[i]   <= dataNext[i];
            end
        end
    end

endmodule

// File: tb/tb_sync_gate_queue.sv
// Directed bench for sync_gate_queue: a DEPTH=4/HANDOVER=2 instance and a
// DEPTH=1/HANDOVER=0 instance share clock and reset.
module tb_sync_gate_queue;

    logic       clk = 1'b0;
    logic       rstn;
    logic       srcWrite, dstRead, clrErr;
    logic [7:0] srcData;
    logic       srcOpen, dstOpen, errWrite, errRead;
    logic [7:0] dstData;
    logic [2:0] dstCount;

    logic       srcWriteB, dstReadB, clrErrB;
    logic [7:0] srcDataB;
    logic       srcOpenB, dstOpenB, errWriteB, errReadB;
    logic [7:0] dstDataB;
    logic [0:0] dstCountB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_gate_queue #(.WIDTH(8), .DEPTH(4), .HANDOVER(2)) dutA (
        .clk_i(clk), .rstn_i(rstn),
        .srcWrite_i(srcWrite), .srcData_i(srcData), .srcOpen_o(srcOpen),
        .dstRead_i(dstRead), .dstData_o(dstData), .dstOpen_o(dstOpen),
        .dstCount_o(dstCount), .clrErr_i(clrErr),
        .errWrite_o(errWrite), .errRead_o(errRead)
    );

    sync_gate_queue #(.WIDTH(8), .DEPTH(1), .HANDOVER(0)) dutB (
        .clk_i(clk), .rstn_i(rstn),
        .srcWrite_i(srcWriteB), .srcData_i(srcDataB), .srcOpen_o(srcOpenB),
        .dstRead_i(dstReadB), .dstData_o(dstDataB), .dstOpen_o(dstOpenB),
        .dstCount_o(dstCountB), .clrErr_i(clrErrB),
        .errWrite_o(errWriteB), .errRead_o(errReadB)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        int n = 0;
        while (!srcOpen && n < 20) begin step(); n++; end
        chk("wr_open", {31'd0, srcOpen}, 32'd1);
        srcWrite = 1'b1;
        srcData  = d;
        step();
        srcWrite = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp);
        int n = 0;
        while (!dstOpen && n < 20) begin step(); n++; end
        chk("rd_open", {31'd0, dstOpen}, 32'd1);
        chk("rd_data", {24'd0, dstData}, {24'd0, exp});
        dstRead = 1'b1;
        step();
        dstRead = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        srcWrite = 1'b0; dstRead = 1'b0; clrErr = 1'b0; srcData = 8'h00;
        srcWriteB = 1'b0; dstReadB = 1'b0; clrErrB = 1'b0; srcDataB = 8'h00;
        step(); step();
        chk("rst_srcOpen",  {31'd0, srcOpen},  32'd1);
        chk("rst_dstOpen",  {31'd0, dstOpen},  32'd0);
        chk("rst_dstData",  {24'd0, dstData},  32'd0);
        chk("rst_dstCount", {29'd0, dstCount}, 32'd0);
        chk("rst_errWrite", {31'd0, errWrite}, 32'd0);
        chk("rst_errRead",  {31'd0, errRead},  32'd0);
        chk("rstB_srcOpen", {31'd0, srcOpenB}, 32'd1);
        chk("rstB_dstOpen", {31'd0, dstOpenB}, 32'd0);
        rstn = 1'b1;
        step();
        chk("rel_srcOpen", {31'd0, srcOpen}, 32'd1);

        // Single write latency: honoured at E0, visible after E3.
        srcWrite = 1'b1; srcData = 8'hA5;
        step();
        srcWrite = 1'b0;
        chk("lat_e0_dstOpen", {31'd0, dstOpen}, 32'd0);
        chk("lat_e0_data_held", {24'd0, dstData}, 32'h0A5);
        step(); step();
        chk("lat_e2_dstOpen", {31'd0, dstOpen}, 32'd0);
        chk("lat_e2_count", {29'd0, dstCount}, 32'd0);
        step();
        chk("lat_e3_dstOpen", {31'd0, dstOpen}, 32'd1);
        chk("lat_e3_count", {29'd0, dstCount}, 32'd1);
        rd(8'hA5);
        chk("after_rd_dstOpen", {31'd0, dstOpen}, 32'd0);
        chk("after_rd_count", {29'd0, dstCount}, 32'd0);
        step(); step(); step();

        // Fill all four slots back-to-back, then overflow.
        for (int k = 1; k <= 4; k++) begin
            srcWrite = 1'b1; srcData = 8'(k);
            step();
        end
        chk("full_srcOpen", {31'd0, srcOpen}, 32'd0);
        srcData = 8'h05;
        step();
        srcWrite = 1'b0;
        chk("ovf_errWrite", {31'd0, errWrite}, 32'd1);
        chk("ovf_srcOpen", {31'd0, srcOpen}, 32'd0);
        step(); step();
        chk("full_count", {29'd0, dstCount}, 32'd4);
        chk("full_errRead", {31'd0, errRead}, 32'd0);

        // One read at t; src slot comes back at t+3.
        chk("rd1_data", {24'd0, dstData}, 32'h01);
        dstRead = 1'b1;
        step();
        dstRead = 1'b0;
        chk("free_t0", {31'd0, srcOpen}, 32'd0);
        step();
        chk("free_t1", {31'd0, srcOpen}, 32'd0);
        step();
        chk("free_t2", {31'd0, srcOpen}, 32'd0);
        step();
        chk("free_t3", {31'd0, srcOpen}, 32'd1);
        chk("free_count", {29'd0, dstCount}, 32'd3);

        // Continue across the pointer wrap; FIFO order must hold.
        rd(8'h02);
        rd(8'h03);
        wr(8'h10);
        wr(8'h11);
        wr(8'h12);
        chk("wrap_full_srcOpen", {31'd0, srcOpen}, 32'd0);
        rd(8'h04);
        wr(8'h14);
        rd(8'h10);
        rd(8'h11);
        rd(8'h12);
        rd(8'h14);
        chk("drain_dstOpen", {31'd0, dstOpen}, 32'd0);
        chk("drain_count", {29'd0, dstCount}, 32'd0);

        // Sticky error flags and clear priority.
        chk("err_pre_read", {31'd0, errRead}, 32'd0);
        chk("err_pre_write", {31'd0, errWrite}, 32'd1);
        dstRead = 1'b1;
        step();
        dstRead = 1'b0;
        chk("err_read_set", {31'd0, errRead}, 32'd1);
        clrErr = 1'b1; dstRead = 1'b1;
        step();
        clrErr = 1'b0; dstRead = 1'b0;
        chk("err_clr_vs_viol", {31'd0, errRead}, 32'd1);
        chk("err_write_cleared", {31'd0, errWrite}, 32'd0);
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        chk("err_read_cleared", {31'd0, errRead}, 32'd0);

        // DEPTH=1, HANDOVER=0: strict alternation, never open to both sides.
        for (int k = 0; k < 3; k++) begin
            chk("b_pre_srcOpen", {31'd0, srcOpenB}, 32'd1);
            chk("b_pre_dstOpen", {31'd0, dstOpenB}, 32'd0);
            srcWriteB = 1'b1; srcDataB = 8'h3C + 8'(k);
            step();
            srcWriteB = 1'b0;
            chk("b_todst_srcOpen", {31'd0, srcOpenB}, 32'd0);
            chk("b_todst_dstOpen", {31'd0, dstOpenB}, 32'd0);
            step();
            chk("b_dst_dstOpen", {31'd0, dstOpenB}, 32'd1);
            chk("b_dst_srcOpen", {31'd0, srcOpenB}, 32'd0);
            chk("b_dst_data", {24'd0, dstDataB}, {24'd0, 8'h3C + 8'(k)});
            dstReadB = 1'b1;
            step();
            dstReadB = 1'b0;
            chk("b_tosrc_dstOpen", {31'd0, dstOpenB}, 32'd0);
            chk("b_tosrc_srcOpen", {31'd0, srcOpenB}, 32'd0);
            step();
        end
        chk("b_errWrite", {31'd0, errWriteB}, 32'd0);
        chk("b_errRead", {31'd0, errReadB}, 32'd0);

        // Reset while two slots are in flight towards dst.
        wr(8'h30);
        wr(8'h31);
        chk("pre_rst_data", {24'd0, dstData}, 32'h30);
        chk("pre_rst_dstOpen", {31'd0, dstOpen}, 32'd0);
        rstn = 1'b0; srcWrite = 1'b1; dstRead = 1'b1; srcData = 8'h77;
        step();
        chk("mid_rst_count", {29'd0, dstCount}, 32'd0);
        chk("mid_rst_dstOpen", {31'd0, dstOpen}, 32'd0);
        chk("mid_rst_srcOpen", {31'd0, srcOpen}, 32'd1);
        chk("mid_rst_data", {24'd0, dstData}, 32'd0);
        rstn = 1'b1; srcWrite = 1'b0; dstRead = 1'b0;
        step(); step(); step(); step();
        chk("post_rst_dstOpen", {31'd0, dstOpen}, 32'd0);
        chk("post_rst_count", {29'd0, dstCount}, 32'd0);
        chk("post_rst_errRead", {31'd0, errRead}, 32'd0);
        chk("post_rst_errWrite", {31'd0, errWrite}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
